token_quantizer: RTL and testbench

TOKEN_QUANTIZER -- requirements
Module: token_quantizer

---
 rtl/tva_pkg.sv | 11 +
 rtl/quant_round_sat.sv | 29 ++
 rtl/token_quantizer.sv | 123 ++++++++++++
 tb/tb_token_quantizer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/tva_pkg.sv
// tva_pkg: precision codes and quantizer shift amounts shared by the precision assigner and the quantizer.
package tva_pkg;
  typedef enum logic [1:0] {
    PREC_INT4 = 2'd0,
    PREC_INT8 = 2'd1,
    PREC_FP16 = 2'd2,
    PREC_RSVD = 2'd3
  } prec_t;
  localparam int SHIFT_INT4 = 12;
  localparam int SHIFT_INT8 = 8;
endpackage

// File: rtl/quant_round_sat.sv
// quant_round_sat: combinational round-half-up + saturate of one Q1.15 element to the requested precision.
//   x        : signed input element
//   prec     : requested precision code
//   q        : quantized value, sign-extended to DATA_WIDTH
//   prec_eff : precision actually applied (reserved code maps to full precision)
module quant_round_sat
  import tva_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  prec_t                 prec,
  output logic [DATA_WIDTH-1:0] q,
  output prec_t                 prec_eff
);
  localparam int W = DATA_WIDTH + 1;
  // One extra bit keeps the rounding add from overflowing near the positive limit.
  function automatic logic [DATA_WIDTH-1:0] rnd_sat(input logic [DATA_WIDTH-1:0] v, input int sh);
    logic signed [W-1:0] r, hi, lo;
    r  = ($signed({v[DATA_WIDTH-1], v}) + $signed(W'(1) << (sh - 1))) >>> sh;
    hi = $signed((W'(1) << (DATA_WIDTH - 1 - sh)) - W'(1));
    lo = ~hi;
    return r > hi ? hi[DATA_WIDTH-1:0] : r < lo ? lo[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
  endfunction
  always_comb begin
    q = prec == PREC_INT4 ? rnd_sat(x, SHIFT_INT4) : prec == PREC_INT8 ? rnd_sat(x, SHIFT_INT8) : x;
    prec_eff = prec == PREC_RSVD ? PREC_FP16 : prec;
  end
endmodule

// File: rtl/token_quantizer.sv
// token_quantizer: latches V and per-token precision on start, then streams every element quantized.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begins a pass when idle; latches token_precision and V_in
//   token_precision   : per-token precision code
//   V_in              : flattened V, element (t,e) at [(t*D+e+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   busy              : pass in progress
//   out_valid/ready   : output handshake, element-major within each token
//   out_data/prec/tok/elem : quantized element, applied code and its position
//   done              : one-cycle pulse after the final transfer
module token_quantizer
  import tva_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L = 8,
  parameter int D = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                token_precision [0:L-1],
  input  logic [DATA_WIDTH*L*D-1:0] V_in,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [1:0]                out_prec,
  output logic [$clog2(L)-1:0]      out_tok,
  output logic [$clog2(D)-1:0]      out_elem,
  output logic                      done
);
  localparam int TW = $clog2(L);
  localparam int EW = $clog2(D);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  prec_t out_prec_q, out_prec_d;
  logic [TW-1:0] out_tok_q, out_tok_d, tok_q, tok_d;
  logic [EW-1:0] out_elem_q, out_elem_d, elem_q, elem_d;
  logic [DATA_WIDTH-1:0] v_q [0:L-1][0:D-1];
  logic [DATA_WIDTH-1:0] v_d [0:L-1][0:D-1];
  prec_t prec_q [0:L-1];
  prec_t prec_d [0:L-1];
  logic [DATA_WIDTH-1:0] q;
  prec_t q_prec;
  logic accept, last_xfer, load_el, elem_wrap;
  assign accept    = state_q == S_IDLE && start;
  assign last_xfer = out_valid_q && out_ready && out_tok_q == TW'(L - 1) && out_elem_q == EW'(D - 1);
  // tok/elem point at the next element to present; the output registers are refilled when
  // they are empty (first EMIT cycle) or when their current element is being taken.
  assign load_el   = state_q == S_EMIT && (!out_valid_q || (out_ready && !last_xfer));
  assign elem_wrap = elem_q == EW'(D - 1);
  quant_round_sat #(.DATA_WIDTH(DATA_WIDTH)) u_qrs (
    .x        (v_q[tok_q][elem_q]),
    .prec     (prec_q[tok_q]),
    .q        (q),
    .prec_eff (q_prec)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_EMIT;
      S_EMIT:  state_d = last_xfer ? S_DONE : S_EMIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    busy_d      = accept ? 1'b1 : last_xfer ? 1'b0 : busy_q;
    done_d      = last_xfer;
    out_valid_d = state_q == S_EMIT && !last_xfer;
    out_data_d  = load_el ? q : out_data_q;
    out_prec_d  = load_el ? q_prec : out_prec_q;
    out_tok_d   = load_el ? tok_q : out_tok_q;
    out_elem_d  = load_el ? elem_q : out_elem_q;
    tok_d       = state_q == S_LOAD ? '0 : load_el && elem_wrap ? tok_q + TW'(1) : tok_q;
    elem_d      = state_q == S_LOAD || (load_el && elem_wrap) ? '0 : load_el ? elem_q + EW'(1) : elem_q;
    for (int t = 0; t < L; t++) begin
      prec_d[t] = accept ? prec_t'(token_precision[t]) : prec_q[t];
      for (int e = 0; e < D; e++) v_d[t][e] = accept ? V_in[(t*D+e)*DATA_WIDTH +: DATA_WIDTH] : v_q[t][e];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_prec_q  <= PREC_INT4;
      out_tok_q   <= '0;
      out_elem_q  <= '0;
      tok_q       <= '0;
      elem_q      <= '0;
      for (int t = 0; t < L; t++) begin
        prec_q[t] <= PREC_INT4;
        for (int e = 0; e < D; e++) v_q[t][e] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_prec_q  <= out_prec_d;
      out_tok_q   <= out_tok_d;
      out_elem_q  <= out_elem_d;
      tok_q       <= tok_d;
      elem_q      <= elem_d;
      prec_q      <= prec_d;
      v_q         <= v_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_prec  = out_prec_q;
  assign out_tok   = out_tok_q;
  assign out_elem  = out_elem_q;
endmodule

// File: tb/tb_token_quantizer.sv
// tb_token_quantizer: directed + randomized passes checked against an arithmetic model of the quantizer.
module tb_token_quantizer;
  localparam int DW = 16, L = 8, D = 4, N = L * D;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [1:0] tp [0:L-1];
  logic [DW*N-1:0] v_in;
  logic busy, out_valid, done;
  logic [DW-1:0] out_data;
  logic [1:0] out_prec;
  logic [2:0] out_tok;
  logic [1:0] out_elem;
  int tests = 0, fails = 0;
  logic [DW-1:0] got [0:N-1];
  logic [DW-1:0] pat [0:6];
  always #5 clk = ~clk;
  token_quantizer #(.DATA_WIDTH(DW), .L(L), .D(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .token_precision(tp), .V_in(v_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_prec(out_prec), .out_tok(out_tok), .out_elem(out_elem), .done(done)
  );
  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Real-valued round-half-up then clamp, straight from the numeric definition.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic [1:0] c);
    int xi, s, lim, v;
    if (c[1]) return x;
    xi  = $signed(x);
    s   = c[0] ? 8 : 12;
    lim = 1 << (15 - s);
    v   = int'($floor(real'(xi) / real'(1 << s) + 0.5));
    if (v > lim - 1) v = lim - 1;
    if (v < -lim) v = -lim;
    return DW'(v);
  endfunction
  task automatic rand_inputs();
    for (int i = 0; i < N; i++) v_in[i*DW +: DW] = DW'($urandom);
    for (int t = 0; t < L; t++) tp[t] = 2'($urandom);
  endtask
  task automatic run_pass(input bit rnd, input bit stall, input bit disturb, input int rst_at);
    logic [DW-1:0] sv [0:N-1];
    logic [1:0] sc [0:L-1];
    logic [23:0] cur, held;
    logic [1:0] ec;
    bit held_v, stalled;
    int n, cyc, first, last, stall_left, t, e;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) sv[i] = v_in[i*DW +: DW];
    for (int i = 0; i < L; i++) sc[i] = tp[i];
    @(negedge clk);
    start = 1'b0;
    chk(busy, 1, "busy_after_start");
    n = 0; cyc = 1; first = -1; last = 0; held_v = 0; stalled = 0; stall_left = 0; held = '0;
    while (n < N && cyc < 1000) begin
      if (stall && !stalled && out_valid && out_tok == 3'd3 && out_elem == 2'd2) begin
        stalled = 1;
        stall_left = 5;
      end
      out_ready = stall_left > 0 ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_left > 0) stall_left--;
      cur = {out_valid, out_data, out_prec, out_tok, out_elem};
      if (held_v) chk(cur, held, "hold_while_not_ready");
      if (out_valid && first < 0) begin
        first = cyc;
        chk(cyc - 1, 2, "first_valid_latency");
      end
      if (out_valid && out_ready) begin
        t = n / D;
        e = n % D;
        ec = sc[t] == 2'd3 ? 2'd2 : sc[t];
        chk({out_data, out_prec, out_tok, out_elem}, {model(sv[n], sc[t]), ec, 3'(t), 2'(e)}, "transfer");
        got[n] = out_data;
        last = cyc;
        n++;
        held_v = 0;
        if (disturb && n == 5) begin
          start = 1'b1;
          rand_inputs();
        end
        if (n == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk({out_valid, done, busy, out_data, out_prec, out_tok, out_elem}, '0, "async_reset_outputs");
          return;
        end
      end else begin
        held_v = out_valid;
        held = cur;
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    if (n < N) begin
      chk(n, N, "pass_timeout");
      return;
    end
    if (!rnd && !stall) chk(last - first, N - 1, "back_to_back_throughput");
    chk({done, out_valid, busy}, 3'b100, "done_pulse");
    @(negedge clk);
    chk({done, out_valid, busy}, 3'b000, "done_single_cycle");
    repeat (3) @(negedge clk);
    chk({done, out_valid, busy}, 3'b000, "idle_after_pass");
  endtask
  initial begin
    pat = '{16'h7FFF, 16'h8000, 16'h0800, 16'h07FF, 16'h7FFF, 16'h0080, 16'hFF7F};
    for (int t = 0; t < L; t++) tp[t] = 2'd0;
    v_in = '0;
    repeat (2) @(negedge clk);
    chk({out_valid, done, busy, out_data, out_prec, out_tok, out_elem}, '0, "reset_state");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk({out_valid, done, busy}, 3'b000, "quiet_after_reset");
    for (int i = 0; i < N; i++) v_in[i*DW +: DW] = DW'(i);
    for (int t = 0; t < L; t++) tp[t] = 2'd2;
    run_pass(0, 0, 0, -1);
    rand_inputs();
    tp[0] = 2'd0;
    tp[1] = 2'd1;
    tp[2] = 2'd3;
    for (int i = 0; i < 7; i++) v_in[i*DW +: DW] = pat[i];
    run_pass(0, 0, 0, -1);
    chk(got[0], 16'h0007, "int4_pos_sat");
    chk(got[1], 16'hFFF8, "int4_neg_sat");
    chk(got[2], 16'h0001, "int4_one");
    chk(got[3], 16'h0000, "int4_round_down");
    chk(got[4], 16'h007F, "int8_pos_sat");
    chk(got[5], 16'h0001, "int8_one");
    chk(got[6], 16'hFFFF, "int8_minus_one");
    chk(got[8], v_in[8*DW +: DW], "rsvd_passthrough");
    rand_inputs();
    run_pass(1, 1, 0, -1);
    rand_inputs();
    run_pass(0, 0, 1, -1);
    rand_inputs();
    run_pass(1, 0, 0, 10);
    repeat (3) @(negedge clk);
    chk({out_valid, done, busy}, 3'b000, "held_in_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk({out_valid, done, busy}, 3'b000, "quiet_after_midpass_reset");
    rand_inputs();
    run_pass(1, 0, 0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
